// File: rtl/digit_match_sequencer.sv
// digit_match_sequencer: drives one shared per-pixel difference unit across
// every pixel of every digit template and reports the template with the
// lowest summed difference as the recognized digit.
module digit_match_sequencer #(
  parameter int NUM_DIGITS = 10,
  parameter int GRID       = 11,
  parameter int RD_LAT     = 1,
  parameter int SUM_W      = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [3:0]       pix_row,
  output logic [3:0]       pix_col,
  output logic [3:0]       tpl_digit,
  input  logic [7:0]       pix_data,
  input  logic [7:0]       tpl_data,
  output logic [7:0]       diff_a,
  output logic [7:0]       diff_b,
  input  logic [7:0]       diff_in,
  output logic [3:0]       digit,
  output logic [SUM_W-1:0] score
);

  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CMP, DONE} state_t;

  state_t            state;
  logic [SUM_W-1:0]  acc;
  logic [SUM_W-1:0]  best_score;
  logic [3:0]        best_digit;
  logic [DW-1:0]     drain_cnt;
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT:0]   vld_shift;
  logic              issue;
  logic              acc_en;
  logic              last_pix;
  logic              take_new;

  // The difference unit sees the memories' read data directly.
  assign diff_a = pix_data;
  assign diff_b = tpl_data;

  // An address is issued on every RUN cycle; its data is usable RD_LAT later.
  assign issue     = (state == RUN);
  assign vld_shift = {vld_pipe, issue};
  assign acc_en    = vld_pipe[RD_LAT-1];
  assign last_pix  = (pix_row == 4'(GRID - 1)) && (pix_col == 4'(GRID - 1));
  // Strict compare so that equal totals keep the earlier (lower) template.
  assign take_new  = (acc < best_score);

  // Valid pipeline matching the memory read latency; flushed on abort so a
  // restart never accumulates stale samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else if (abort) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= vld_shift[RD_LAT-1:0];
    end
  end

  // Main controller: address walk, accumulation, per-template compare, result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      digit      <= '0;
      score      <= '0;
      pix_row    <= '0;
      pix_col    <= '0;
      tpl_digit  <= '0;
      acc        <= '0;
      best_score <= '0;
      best_digit <= '0;
      drain_cnt  <= '0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // Later assignments in the case below (clears) take priority.
      if (acc_en) begin
        acc <= acc + SUM_W'(diff_in);
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state      <= RUN;
            busy       <= 1'b1;
            best_score <= '1;
            best_digit <= '0;
            tpl_digit  <= '0;
            pix_row    <= '0;
            pix_col    <= '0;
            acc        <= '0;
          end
        end
        RUN: begin
          if (last_pix) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else if (pix_col == 4'(GRID - 1)) begin
            pix_col <= '0;
            pix_row <= pix_row + 4'd1;
          end else begin
            pix_col <= pix_col + 4'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(RD_LAT - 1)) begin
            state <= CMP;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        CMP: begin
          if (take_new) begin
            best_score <= acc;
            best_digit <= tpl_digit;
          end
          acc     <= '0;
          pix_row <= '0;
          pix_col <= '0;
          if (tpl_digit == 4'(NUM_DIGITS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            digit <= take_new ? tpl_digit : best_digit;
            score <= take_new ? acc : best_score;
          end else begin
            tpl_digit <= tpl_digit + 4'd1;
            state     <= RUN;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_match_sequencer.sv
// Directed bench for digit_match_sequencer: frame buffer and template ROM
// models with one-cycle registered reads, and a selectable difference unit.
module tb_digit_match_sequencer;

  localparam int SUM_W = 15;
  localparam int NPIX  = 121;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [3:0]       pix_row;
  logic [3:0]       pix_col;
  logic [3:0]       tpl_digit;
  logic [7:0]       pix_data;
  logic [7:0]       tpl_data;
  logic [7:0]       diff_a;
  logic [7:0]       diff_b;
  logic [7:0]       diff_in;
  logic [3:0]       digit;
  logic [SUM_W-1:0] score;

  logic [7:0] rom [0:9][0:NPIX-1];
  logic [7:0] fbuf [0:NPIX-1];
  int         diff_mode;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc;
  bit         saw_done;

  always #5 clk = ~clk;

  digit_match_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .tpl_digit (tpl_digit),
    .pix_data  (pix_data),
    .tpl_data  (tpl_data),
    .diff_a    (diff_a),
    .diff_b    (diff_b),
    .diff_in   (diff_in),
    .digit     (digit),
    .score     (score)
  );

  // Memory models with one-cycle registered read.
  always @(posedge clk) begin
    int a;
    int t;
    a = int'(pix_row) * 11 + int'(pix_col);
    t = int'(tpl_digit);
    if (a >= NPIX) a = 0;
    if (t > 9) t = 0;
    pix_data <= fbuf[a];
    tpl_data <= rom[t][a];
  end

  // Shared difference unit: 0 = always zero, 1 = |a-b|, 2 = constant 255.
  always_comb begin
    diff_in = 8'd0;
    if (diff_mode == 1) diff_in = (diff_a > diff_b) ? diff_a - diff_b : diff_b - diff_a;
    else if (diff_mode == 2) diff_in = 8'd255;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mems();
    for (int p = 0; p < NPIX; p++) begin
      fbuf[p] = 8'd0;
      for (int t = 0; t < 10; t++) rom[t][p] = 8'd0;
    end
  endtask

  // Pulse start, then count cycles (cycle 0 = first RUN cycle) until done.
  task automatic run_to_done(output int cycles);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic report_run(input string tag, input int exp_digit, input int exp_score);
    int c;
    run_to_done(c);
    check_val({tag, "_cycle"}, c, 1230);
    check_val({tag, "_digit"}, int'(digit), exp_digit);
    check_val({tag, "_score"}, int'(score), exp_score);
    $display("run %s: done at cycle %0d digit=%0d score=%0d", tag, c, digit, score);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    diff_mode = 0;
    clear_mems();
    repeat (3) @(negedge clk);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_digit", int'(digit), 0);
    check_val("rst_score", int'(score), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // All-zero differences: tie everywhere, lowest index wins.
    diff_mode = 0;
    report_run("zero", 0, 0);
    @(negedge clk);
    check_val("zero_busy_after", int'(busy), 0);

    // Ten distinct templates, frame equals template 4.
    diff_mode = 1;
    for (int t = 0; t < 10; t++)
      for (int p = 0; p < NPIX; p++) rom[t][p] = 8'((t * 23 + p * 7) % 256);
    for (int p = 0; p < NPIX; p++) fbuf[p] = rom[4][p];
    report_run("match4", 4, 0);

    // Templates 3 and 7 both total 500, others exceed it: lower index wins.
    clear_mems();
    for (int t = 0; t < 10; t++) begin
      rom[t][0] = 8'd250;
      rom[t][1] = 8'd250;
      rom[t][2] = (t == 3 || t == 7) ? 8'd0 : 8'(t + 1);
    end
    report_run("tie37", 3, 500);

    // Constant 255 per pixel: full-scale total with no wrap.
    diff_mode = 2;
    report_run("full", 0, 30855);

    // Best template is the last one: template t differs by 100-5t in one pixel.
    diff_mode = 1;
    clear_mems();
    for (int t = 0; t < 10; t++) rom[t][60] = 8'(100 - 5 * t);
    report_run("last9", 9, 55);

    // Abort at cycle 400: idle next cycle, no done, results held.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (400) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_val("abort_busy", int'(busy), 0);
    saw_done = 1'b0;
    repeat (1300) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_val("abort_no_done", int'(saw_done), 0);
    check_val("abort_digit_held", int'(digit), 9);
    check_val("abort_score_held", int'(score), 55);
    $display("abort: busy=%0d digit=%0d score=%0d", busy, digit, score);
    report_run("after_abort", 9, 55);

    // Abort together with start in IDLE: stays idle.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check_val("abort_start_idle", int'(busy), 0);
    @(negedge clk);
    check_val("abort_start_idle2", int'(busy), 0);

    // Start re-pulsed at cycle 50 is ignored; done still at 1230.
    diff_mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 50) start = 1'b1;
      else start = 1'b0;
    end
    check_val("restart_ignored_cycle", cyc, 1230);
    check_val("restart_ignored_score", int'(score), 30855);
    $display("restart mid-run: done at cycle %0d score=%0d", cyc, score);

    // Asynchronous reset at cycle 700.
    diff_mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (700) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_busy", int'(busy), 0);
    check_val("mid_rst_digit", int'(digit), 0);
    check_val("mid_rst_score", int'(score), 0);
    check_val("mid_rst_addr", int'({pix_row, pix_col, tpl_digit}), 0);
    @(negedge clk); reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (1300) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check_val("mid_rst_stays_idle", int'(saw_done), 0);
    $display("mid-run reset: busy=%0d digit=%0d score=%0d", busy, digit, score);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
